// File: rtl/lh_stream_pkg.sv
// Shared constants and helpers for the lh_stream buffer.
package lh_stream_pkg;

   // Out1_COUNT is always a single token.
   localparam logic [15:0] COUNT_ONE   = 16'h0001;
   // Edges after reset release before the block starts trading tokens.
   localparam int unsigned KICK_CYCLES = 3;
   localparam int unsigned KICK_W      = 2;

   // Occupancy must represent 0..depth inclusive, hence depth+1 states.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/lh_stream_fifo.sv
// Register-array FIFO with a separate occupancy counter for full/empty.
module lh_stream_fifo
   import lh_stream_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned LVL_W = occ_width(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [LVL_W-1:0]  o_level
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_level == LVL_W'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/lh_stream_buffer.sv
// Stream buffer: start-up kick, per-line horizontal decimation, FIFO decoupling.
module lh_stream_buffer
   import lh_stream_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned DECIM    = 1,
   parameter int unsigned LINE_LEN = 512,
   localparam int unsigned LVL_W   = occ_width(DEPTH)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] In1_DATA,
   input  logic [15:0]       In1_COUNT,
   input  logic              In1_SEND,
   output logic              In1_ACK,
   output logic [DATA_W-1:0] Out1_DATA,
   output logic [15:0]       Out1_COUNT,
   output logic              Out1_SEND,
   input  logic              Out1_RDY,
   input  logic              Out1_ACK,
   output logic [LVL_W-1:0]  LEVEL
);

   localparam logic [7:0]  PHASE_LAST = 8'(DECIM - 1);
   localparam logic [15:0] LINE_LAST  = 16'(LINE_LEN - 1);

   logic [KICK_W-1:0] r_kick_cnt;
   logic              r_run;
   logic [7:0]        r_phase;
   logic [15:0]       r_line;
   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_push;
   logic              w_unused;

   // Producer count and consumer ack carry no information for this block.
   assign w_unused = ^{In1_COUNT, Out1_ACK};

   // Full blocks acceptance even if a pop happens in the same cycle.
   assign w_accept   = r_run & In1_SEND & ~w_full;
   assign w_push     = w_accept & (r_phase == 8'd0);
   assign In1_ACK    = w_accept;
   assign Out1_SEND  = r_run & ~w_empty & Out1_RDY;
   assign Out1_COUNT = COUNT_ONE;

   // Start-up kick: run rises on the KICK_CYCLES-th edge after reset release.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_kick_cnt <= '0;
         r_run      <= 1'b0;
      end else if (!r_run) begin
         r_kick_cnt <= r_kick_cnt + KICK_W'(1);
         if (r_kick_cnt == KICK_W'(KICK_CYCLES - 1)) r_run <= 1'b1;
      end
   end

   // Decimation phase and line position advance on every accepted token.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_phase <= '0;
         r_line  <= '0;
      end else if (w_accept) begin
         if (r_line == LINE_LAST) begin
            // Line end restarts decimation so each line keeps its first token.
            r_line  <= '0;
            r_phase <= '0;
         end else begin
            r_line  <= r_line + 16'd1;
            r_phase <= (r_phase == PHASE_LAST) ? 8'd0 : r_phase + 8'd1;
         end
      end
   end

   lh_stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_push  (w_push),
      .i_data  (In1_DATA),
      .i_pop   (Out1_SEND),
      .o_data  (Out1_DATA),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (LEVEL)
   );

endmodule

// File: doc/lh_stream_buffer.md
# lh_stream_buffer

Parametrised successor to the single-token line-pass actor: accepts tokens on the In1 port with the SEND/ACK handshake, optionally decimates them in the horizontal (per-line) direction, buffers survivors in a DEPTH-entry FIFO, and emits them on the Out1 port under Out1_RDY flow control. Sits between visual-saliency pipeline stages where the plain pass-through actor is replaced, decoupling producer and consumer stalls. Includes the same post-reset start-up kick as existing actors.

## Interface
Parameters:
- DATA_W, 16, token width for In1_DATA/Out1_DATA.
- DEPTH, 4, FIFO entries; power of two, 2..64.
- DECIM, 1, keep one token in every DECIM; 1 = pass all; 1..255.
- LINE_LEN, 512, accepted tokens per line; decimation phase restarts each line; 1..65535.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- In1_DATA  in  DATA_W  input token.
- In1_COUNT  in  16  producer token count; ignored.
- In1_SEND  in  1  producer has a token.
- In1_ACK  out  1  token consumed this cycle.
- Out1_DATA  out  DATA_W  output token, valid when Out1_SEND=1.
- Out1_COUNT  out  16  constant 16'h0001.
- Out1_SEND  out  1  token emitted this cycle.
- Out1_RDY  in  1  consumer can take a token.
- Out1_ACK  in  1  consumer acknowledge; ignored.
- LEVEL  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Start-up: after RESET rises, internal `run` asserts on the 3rd rising CLK edge; until then In1_ACK=0, Out1_SEND=0.
- Accept: In1_ACK = run & In1_SEND & ~full (combinational). Full blocks ACK even if a pop occurs the same cycle (no bypass).
- Decimation: phase counter 0..DECIM-1 advances on each accepted token, wraps to 0. Token pushed only when phase==0; other accepted tokens are ACKed and dropped.
- Line counter 0..LINE_LEN-1 advances on each accepted token (kept or dropped); on wrap, phase also forced to 0 regardless of its value.
- Emit: Out1_SEND = run & ~empty & Out1_RDY (combinational); Out1_DATA = FIFO head; pop on Out1_SEND.
- Simultaneous push and pop when not full and not empty: both happen, LEVEL unchanged.
- Pointers log2(DEPTH) bits with wrap; full/empty from a separate occupancy counter (0..DEPTH).
- Out1_DATA when Out1_SEND=0: FIFO head, don't-care for checking.

## Timing
- Reset (RESET=0, asynchronous): pointers, LEVEL, phase, line counter, run/kick registers = 0; In1_ACK=0, Out1_SEND=0, Out1_COUNT=16'h0001 always.
- Latency: token accepted at edge t is emittable in the cycle after t (one-cycle minimum, no same-cycle fall-through).
- Throughput: one token per cycle in and out when DECIM=1 and Out1_RDY=1 continuously.
- Reset mid-operation: all buffered tokens discarded, counters cleared, start-up kick repeats.
- LEVEL updates at the edge following push/pop.

## Structure
- Package lh_stream_pkg: COUNT_ONE = 16'h0001, KICK_CYCLES = 3, helper function for occupancy width.
- One sub-module: lh_stream_fifo (DEPTH×DATA_W register array, push/pop/full/empty/level). Top holds kicker, decimation/line counters and handshake logic.

## Test plan
- Start-up: release RESET with In1_SEND=1 held, Out1_RDY=1 -> In1_ACK=0 for first 2 edges, first ACK in cycle after 3rd edge; first Out1_SEND one cycle later with matching data.
- Stream DECIM=1, DEPTH=4: push 0x0001..0x0010 with Out1_RDY=1 -> Out1 emits same 16 values in order, one per cycle, LEVEL ≤1.
- Backpressure: Out1_RDY=0, push 6 tokens -> 4 ACKed, LEVEL=4, In1_ACK=0 while full even when Out1_RDY rises same cycle; after draining, order preserved.
- Decimation DECIM=3, LINE_LEN=7: inputs 0..13 -> outputs 0,3,6,7,10,13 (phase restarts at line boundary tokens 7).
- Reset mid-stream: LEVEL=3, pulse RESET low for 1 cycle -> LEVEL=0, Out1_SEND=0 immediately, no old data emitted after restart.
- Random SEND/RDY, DECIM=2, 10k tokens -> scoreboard match, never overflow/underflow, Out1_COUNT always 1.
